// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank driver and future JK-based generators.
package jk_pkg;

  // Operation codes carried on req_op
  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_TOGGLE = 2'd2;
  localparam logic [1:0] OP_INC    = 2'd3;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

endpackage

// File: rtl/jk_bank_driver_if.sv
// Request/bank bus between a requester and the JK bank driver.
// q_fb travels on the same bus so the driver sees the bank read-back.
interface jk_bank_driver_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_data;
  logic [7:0]       req_steps;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             done;
  logic             err;

  // Requester side (also supplies the bank read-back)
  modport master (
    output req_valid, req_op, req_data, req_steps, q_fb,
    input  req_ready, j, k, done, err
  );

  // Driver side
  modport slave (
    input  req_valid, req_op, req_data, req_steps, q_fb,
    output req_ready, j, k, done, err
  );
endinterface

// File: rtl/jk_excite.sv
// Combinational JK excitation: per bit, J/K needed to move cur to nxt.
// Don't-care terms are resolved to 0; toggle mode drives J=K=mask.
module jk_excite #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  input  logic [WIDTH-1:0] tog_mask,
  input  logic             tog_en,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      // 0->1 sets via J, 1->0 clears via K, holds use neither
      assign j[gi] = tog_en ? tog_mask[gi] : (~cur[gi] &  nxt[gi]);
      assign k[gi] = tog_en ? tog_mask[gi] : ( cur[gi] & ~nxt[gi]);
    end
  endgenerate

endmodule

// File: rtl/jk_ff.sv
// Single JK flip-flop: the storage element of the driven bank.
module JK_ff (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  // Classic JK behaviour: hold, reset, set, toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// JK bank driver: turns LOAD/CLEAR/TOGGLE/INC requests into one-cycle J/K
// pulses, waits a cycle for the bank to settle, then verifies q_fb.
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  jk_bank_driver_if.slave     bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [7:0]       steps_q, steps_d;

  // Step inputs: first step starts from live q_fb, later INC steps from the
  // value just verified (expected_q)
  logic [WIDTH-1:0] step_cur;
  logic [WIDTH-1:0] step_nxt;
  logic             step_tog;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  // Select current/next values for the excitation of the upcoming step
  always_comb begin
    step_cur = bus.q_fb;
    step_nxt = bus.q_fb;
    step_tog = 1'b0;
    if (state_q == ST_CHECK) begin
      step_cur = expected_q;
      step_nxt = expected_q + ONE;
    end else begin
      case (bus.req_op)
        OP_LOAD:   step_nxt = bus.req_data;
        OP_CLEAR:  step_nxt = '0;
        OP_TOGGLE: begin
          step_nxt = bus.q_fb ^ bus.req_data;
          step_tog = 1'b1;
        end
        default:   step_nxt = bus.q_fb + ONE;
      endcase
    end
  end

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .cur      (step_cur),
    .nxt      (step_nxt),
    .tog_mask (bus.req_data),
    .tog_en   (step_tog),
    .j        (exc_j),
    .k        (exc_k)
  );

  // Sequencer next-state and register next values
  always_comb begin
    state_d    = state_q;
    j_d        = '0;
    k_d        = '0;
    ready_d    = ready_q;
    done_d     = 1'b0;
    err_d      = err_q;
    shadow_d   = shadow_q;
    expected_d = expected_q;
    steps_d    = steps_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          ready_d  = 1'b0;
          err_d    = 1'b0;
          shadow_d = bus.q_fb;
          if (bus.req_op == OP_INC && bus.req_steps == 8'd0) begin
            // Zero-step INC: skip the bank, finish on the next edge
            steps_d    = 8'd0;
            expected_d = bus.q_fb;
            state_d    = ST_CHECK;
          end else begin
            steps_d    = (bus.req_op == OP_INC) ? bus.req_steps : 8'd1;
            j_d        = exc_j;
            k_d        = exc_k;
            expected_d = step_nxt;
            state_d    = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        // J/K fall back to 0 by default; bank has sampled them
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (steps_q == 8'd0) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.q_fb != expected_q) begin
          // Read-back mismatch abandons any remaining steps
          err_d   = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (steps_q > 8'd1) begin
          steps_d    = steps_q - 8'd1;
          shadow_d   = expected_q;
          j_d        = exc_j;
          k_d        = exc_k;
          expected_d = step_nxt;
          state_d    = ST_DRIVE;
        end else begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      j_q        <= '0;
      k_q        <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      shadow_q   <= '0;
      expected_q <= '0;
      steps_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      k_q        <= k_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      shadow_q   <= shadow_d;
      expected_q <= expected_d;
      steps_q    <= steps_d;
    end
  end

  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.req_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/jk_bank_driver.md
# jk_bank_driver

Sequencer that drives the J/K inputs of an external bank of `WIDTH` JK flip-flops: the writer side of the JK register interface. It accepts one operation per valid/ready request (load, clear, toggle-mask, or multi-step increment). It converts each desired state change into J/K excitation, reads back the bank's `q` outputs, and reports completion and mismatch. It sits between control logic and any JK-built register or counter.

## Interface
- `WIDTH`, default 4: number of JK flip-flops in the driven bank (≥1).
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: driver idle and able to accept a request.
- `req_op` input 2: operation code. 0 = LOAD, 1 = CLEAR, 2 = TOGGLE, 3 = INC.
- `req_data` input WIDTH: LOAD value, or TOGGLE mask. Ignored for CLEAR and INC.
- `req_steps` input 8: INC step count. Ignored for other ops.
- `q_fb` input WIDTH: `q` outputs of the JK bank.
- `j` output WIDTH: J inputs of the bank, registered.
- `k` output WIDTH: K inputs of the bank, registered.
- `done` output 1: one-cycle pulse when the operation finishes or aborts.
- `err` output 1: sticky read-back mismatch flag for the current/last operation.

## Operation
- **States:** IDLE, DRIVE, CHECK.
- **Reset values:** state = IDLE, `j` = 0, `k` = 0, `req_ready` = 1, `done` = 0, `err` = 0. Reset mid-operation discards the operation; no `done` is produced.
- **Accept:** a request is accepted on an edge where state = IDLE and `req_valid` = 1. On that edge:
  - `shadow` ← `q_fb`.
  - `err` ← 0.
  - `steps_left` ← 1, except for INC, where it is `req_steps`.
- **Excitation per bit** (cur → next): 0→0: J=0,K=0; 0→1: J=1,K=0; 1→0: J=0,K=1; 1→1: J=0,K=0. Don't-care terms are always driven 0.
- **TOGGLE exception:** bits set in the mask get J=1,K=1 and next = ~cur. Bits clear in the mask get J=0,K=0.
- **Next value by op:**
  - LOAD: `req_data`.
  - CLEAR: 0.
  - TOGGLE: `shadow ^ mask`.
  - INC: `shadow + 1` modulo 2^WIDTH; all-ones wraps to 0.
- **Step:** register `j`/`k` from the excitation of (`shadow`, next) and set `expected` ← next. Then go to DRIVE.
- **DRIVE → CHECK:** at the next edge, `j` = `k` = 0 and state = CHECK.
- **CHECK:** compare `q_fb` with `expected`.
  - Mismatch: set `err`, pulse `done`, go to IDLE. Remaining steps are abandoned.
  - Match with `steps_left` > 1: decrement `steps_left`, set `shadow` ← `expected`, perform the next step.
  - Otherwise: pulse `done`, go to IDLE.
- **INC with `req_steps` = 0:** no J/K activity. `done` pulses on the edge after acceptance.
- **Request during busy:** `req_ready` = 0 in DRIVE and CHECK, so the request is not accepted and must be held by the requester.
- **Back-to-back:** `req_ready` returns to 1 on the same edge `done` rises. A new request may be accepted on the following edge.

## Timing
- Acceptance edge E0: `j`/`k` valid during cycle E0→E1.
- The bank samples at E1. `j`/`k` return to 0 at E1.
- `q_fb` is checked at E2, where `done` (or the next step) is registered.
- Cost per step is 2 cycles. A 1-step op sets `done` high at E2, for the cycle E2→E3. An N-step INC sets `done` at E(2N).
- `j`/`k` are never both driven high except for TOGGLE mask bits. They are never nonzero outside DRIVE.
- `err` holds after `done` until the next acceptance.

## Structure
- **Shared package `jk_pkg`:**
  - Op-code localparams `OP_LOAD`, `OP_CLEAR`, `OP_TOGGLE`, `OP_INC`.
  - State encodings `ST_IDLE`, `ST_DRIVE`, `ST_CHECK`.
- **Sub-module `jk_excite`:** combinational, WIDTH-parameterised. Inputs: `cur`, `nxt`, `tog_mask`, `tog_en`. Outputs: `j`, `k`. Reused by any future JK-based counter generator.
- **Top level:** FSM, `shadow`/`expected`/`steps_left` registers, and the output registers.
- **Bench:** instantiates one `JK_ff` per bit as the driven bank, sharing `clk` and `reset`.

## Test plan
- **Reset:** reset, then LOAD 4'b1010 → at E1 `j`=1010, `k`=0000; `done` at E2; bank `q`=1010; `err`=0.
- **CLEAR from 1111:** → `k`=1111, `j`=0000 for one cycle; `q`=0000; `done` after 2 cycles.
- **TOGGLE:** mask 0110 on `q`=1010 → `j`=`k`=0110; `q`=1100; bits 3 and 0 unchanged.
- **INC wrap:** INC `req_steps`=3 from `q`=1110 → `q` sequence 1111, 0000, 0001; `done` 6 cycles after acceptance; `req_steps`=0 → `done` after 1 cycle, `j`=`k`=0 throughout.
- **Fault:** force bank bit 2 stuck-at-0, then LOAD 0100 → `err`=1 with `done`; INC `req_steps`=5 with the same fault aborts at the first mismatching step.
- **Busy/reset:** `req_valid` held during busy is accepted only after `done`; reset asserted in CHECK → next cycle IDLE, `j`=`k`=0, no `done`.
